// File: rtl/parity_frame_gen.sv
// parity_frame_gen
//   Pass-through beat stage with one cycle of latency. It adds a parity bit to
//   each beat, a running parity over each frame, an optional check of the frame
//   parity, and a saturating counter of mismatched frames.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid/in_ready          upstream handshake (in_ready = !out_valid || out_ready)
//   in_data[DATA_W]            beat data
//   in_last                    final beat of the frame
//   in_par, chk_en             expected frame parity and check enable, both taken on the last beat
//   clr_cnt                    synchronous clear of err_cnt; wins over an increment
//   out_valid/out_ready        downstream handshake
//   out_data, out_last         registered copies of the accepted beat
//   out_par                    parity of this beat alone
//   frame_par, par_err         frame parity and check result, meaningful on a last beat only
//   err_cnt[CNT_W]             saturating count of mismatched frames
//
// FSM states
//   state      | meaning
//   S_IDLE     | no frame in progress; the next accepted beat starts a new frame
//   S_IN_FRAME | at least one non-last beat of the current frame has been accepted
module parity_frame_gen #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  input  logic              chk_en,
  input  logic              clr_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_last,
  output logic              frame_par,
  output logic              par_err,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_IN_FRAME = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_acc;
  logic                w_acc_nxt;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_par;
  logic                r_out_last;
  logic                r_frame_par;
  logic                r_par_err;
  logic [CNT_W-1:0]    r_err_cnt;

  logic                w_accept;
  logic                w_xfer_out;
  logic                w_beat_xor;
  logic                w_acc_eff;
  logic                w_frame_par;
  logic                w_par_err;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_xfer_out = r_out_valid && out_ready;
  assign w_beat_xor = ^in_data;

  // A leftover accumulator value must not leak into a frame started in IDLE.
  assign w_acc_eff   = (r_state == S_IN_FRAME) ? r_acc : 1'b0;
  assign w_frame_par = w_acc_eff ^ w_beat_xor ^ ODD;
  assign w_par_err   = in_last && chk_en && (w_frame_par != in_par);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_acc_nxt = w_beat_xor;
          if (!in_last) w_state_nxt = S_IN_FRAME;
        end
        S_IN_FRAME: begin
          w_acc_nxt = r_acc ^ w_beat_xor;
          if (in_last) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The output register loads only on an accepted beat. It therefore holds
  // steady while a pending beat waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_par   <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_par <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= in_data;
        r_out_par   <= w_beat_xor ^ ODD;
        r_out_last  <= in_last;
        r_frame_par <= in_last ? w_frame_par : 1'b0;
        r_par_err   <= w_par_err;
      end else if (w_xfer_out) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // The count advances when the error beat leaves the block, not when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_xfer_out && r_out_last && r_par_err && (r_err_cnt != L_CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_par   = r_out_par;
  assign out_last  = r_out_last;
  assign frame_par = r_frame_par;
  assign par_err   = r_par_err;
  assign err_cnt   = r_err_cnt;

endmodule
